// File: rtl/memory_access_unit.sv
// Purpose : executes one sequencer memory op per instruction; holds the 9-bit MAR and drives the RAM bus.
// Latency : address/NOP ops -> done 1 cycle after accept; READ/WRITE -> done 1 cycle after ack (min 2).
// Backpr. : op_ready_o only in IDLE; bus waits on mem_ack_i, aborted with err_o after TIMEOUT_CYCLES.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   op_valid_i / op_ready_o       operation handshake from the control sequencer
//   op_i, mode_i, operand_i       memory_op_e, memory_addr_mode_e, address or offset
//   wdata_i / rdata_o             store data in, last loaded data out
//   mar_o                         current memory address register
//   done_o, err_o                 one-cycle completion / error pulses
//   mem_req_o .. mem_ack_i        external RAM/IO bus
module memory_access_unit #(
  parameter int ADDR_W         = 9,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid_i,
  output logic              op_ready_o,
  input  logic [2:0]        op_i,
  input  logic              mode_i,
  input  logic [ADDR_W-1:0] operand_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic [ADDR_W-1:0] mar_o,
  output logic              done_o,
  output logic              err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i
);

  typedef enum logic [2:0] {
    OP_NOP      = 3'd0,
    OP_READ     = 3'd1,
    OP_WRITE    = 3'd2,
    OP_ABSOLUTE = 3'd3,
    OP_REL_SUB  = 3'd4,
    OP_REL_ADD  = 3'd5
  } memory_op_e;

  typedef enum logic {
    MODE_ABSOLUTE = 1'b0,
    MODE_RELATIVE = 1'b1
  } memory_addr_mode_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Counter wide enough to hold TIMEOUT_CYCLES-1; one bit when the timeout is disabled.
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_e            state;
  logic [TW-1:0]     tcnt;
  logic [ADDR_W-1:0] mar;
  logic [ADDR_W-1:0] ea;
  memory_op_e        op;
  memory_addr_mode_e mode;

  assign op         = memory_op_e'(op_i);
  assign mode       = memory_addr_mode_e'(mode_i);
  assign op_ready_o = (state == S_IDLE);
  assign mar_o      = mar;

  // Effective address for loads/stores; the add wraps modulo 2^ADDR_W by width.
  assign ea = (mode == MODE_RELATIVE) ? mar + operand_i : operand_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      tcnt        <= '0;
      mar         <= '0;
      rdata_o     <= '0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (op_valid_i) begin
            case (op)
              OP_READ, OP_WRITE: begin
                state      <= S_BUS;
                tcnt       <= '0;
                mem_req_o  <= 1'b1;
                mem_addr_o <= ea;
                mem_we_o   <= (op == OP_WRITE);
                if (op == OP_WRITE) mem_wdata_o <= wdata_i;
              end
              OP_ABSOLUTE: begin
                mar    <= operand_i;
                state  <= S_DONE;
                done_o <= 1'b1;
              end
              OP_REL_ADD: begin
                mar    <= mar + operand_i;
                state  <= S_DONE;
                done_o <= 1'b1;
              end
              OP_REL_SUB: begin
                mar    <= mar - operand_i;
                state  <= S_DONE;
                done_o <= 1'b1;
              end
              OP_NOP: begin
                state  <= S_DONE;
                done_o <= 1'b1;
              end
              default: begin
                // Undefined opcodes complete like a NOP but flag the error.
                state  <= S_DONE;
                done_o <= 1'b1;
                err_o  <= 1'b1;
              end
            endcase
          end
        end
        S_BUS: begin
          // Ack is checked first so an ack on the last allowed cycle still succeeds.
          if (mem_ack_i) begin
            state     <= S_DONE;
            mem_req_o <= 1'b0;
            done_o    <= 1'b1;
            if (!mem_we_o) rdata_o <= mem_rdata_i;
          end else if ((TIMEOUT_CYCLES > 0) && (tcnt == T_LAST)) begin
            state     <= S_DONE;
            mem_req_o <= 1'b0;
            done_o    <= 1'b1;
            err_o     <= 1'b1;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access_unit.sv
module tb_memory_access_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       op_valid_i;
  logic       op_ready_o;
  logic [2:0] op_i;
  logic       mode_i;
  logic [8:0] operand_i;
  logic [7:0] wdata_i;
  logic [7:0] rdata_o;
  logic [8:0] mar_o;
  logic       done_o;
  logic       err_o;
  logic       mem_req_o;
  logic       mem_we_o;
  logic [8:0] mem_addr_o;
  logic [7:0] mem_wdata_o;
  logic [7:0] mem_rdata_i;
  logic       mem_ack_i;

  int checks = 0;
  int errors = 0;

  memory_access_unit #(.ADDR_W(9), .DATA_W(8), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .op_valid_i(op_valid_i), .op_ready_o(op_ready_o),
    .op_i(op_i), .mode_i(mode_i), .operand_i(operand_i), .wdata_i(wdata_i),
    .rdata_o(rdata_o), .mar_o(mar_o), .done_o(done_o), .err_o(err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operation for exactly one edge (unit must be ready).
  task automatic issue(input logic [2:0] op, input logic mode, input logic [8:0] opnd,
                       input logic [7:0] wd);
    op_valid_i = 1'b1;
    op_i       = op;
    mode_i     = mode;
    operand_i  = opnd;
    wdata_i    = wd;
    tick();
    op_valid_i = 1'b0;
    op_i       = 3'd0;
    operand_i  = 9'h000;
    wdata_i    = 8'h00;
  endtask

  initial begin
    int n;
    int dones;
    rst = 1'b1; op_valid_i = 1'b0; op_i = 3'd0; mode_i = 1'b0;
    operand_i = 9'h000; wdata_i = 8'h00; mem_rdata_i = 8'h00; mem_ack_i = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst_done", 16'(done_o), 16'h0);
    chk("rst_err", 16'(err_o), 16'h0);
    chk("rst_req", 16'(mem_req_o), 16'h0);
    chk("rst_we", 16'(mem_we_o), 16'h0);
    chk("rst_addr", 16'(mem_addr_o), 16'h000);
    chk("rst_wdata", 16'(mem_wdata_o), 16'h00);
    chk("rst_mar", 16'(mar_o), 16'h000);
    chk("rst_rdata", 16'(rdata_o), 16'h00);
    chk("rst_ready", 16'(op_ready_o), 16'h1);

    // Ack outside BUS is ignored
    mem_ack_i = 1'b1; mem_rdata_i = 8'hEE;
    tick();
    chk("idle_ack_done", 16'(done_o), 16'h0);
    chk("idle_ack_rdata", 16'(rdata_o), 16'h00);
    mem_ack_i = 1'b0; mem_rdata_i = 8'h00;

    // ABSOLUTE 0x1F0, REL_ADD 0x020 (wrap), REL_SUB 0x011 (wrap)
    issue(3'd3, 1'b0, 9'h1F0, 8'h00);
    chk("abs_done", 16'(done_o), 16'h1);
    chk("abs_mar", 16'(mar_o), 16'h1F0);
    chk("abs_ready_busy", 16'(op_ready_o), 16'h0);
    tick();
    chk("abs_done_clr", 16'(done_o), 16'h0);
    chk("abs_ready", 16'(op_ready_o), 16'h1);
    issue(3'd5, 1'b0, 9'h020, 8'h00);
    chk("add_done", 16'(done_o), 16'h1);
    chk("add_mar_wrap", 16'(mar_o), 16'h010);
    tick();
    issue(3'd4, 1'b0, 9'h011, 8'h00);
    chk("sub_done", 16'(done_o), 16'h1);
    chk("sub_mar_wrap", 16'(mar_o), 16'h1FF);
    tick();

    // WRITE relative to MAR=0x100, ack on 3rd BUS cycle
    issue(3'd3, 1'b0, 9'h100, 8'h00);
    tick();
    issue(3'd2, 1'b1, 9'h005, 8'hA5);
    for (int c = 1; c <= 3; c++) begin
      if (c == 3) mem_ack_i = 1'b1;
      chk($sformatf("wr_req_c%0d", c), 16'(mem_req_o), 16'h1);
      chk($sformatf("wr_addr_c%0d", c), 16'(mem_addr_o), 16'h105);
      chk($sformatf("wr_we_c%0d", c), 16'(mem_we_o), 16'h1);
      chk($sformatf("wr_wdata_c%0d", c), 16'(mem_wdata_o), 16'hA5);
      chk($sformatf("wr_nodone_c%0d", c), 16'(done_o), 16'h0);
      tick();
    end
    mem_ack_i = 1'b0;
    chk("wr_done", 16'(done_o), 16'h1);
    chk("wr_err", 16'(err_o), 16'h0);
    chk("wr_req_drop", 16'(mem_req_o), 16'h0);
    chk("wr_mar_kept", 16'(mar_o), 16'h100);
    tick();

    // READ absolute 0x042, ack in first BUS cycle
    issue(3'd1, 1'b0, 9'h042, 8'h00);
    chk("rd_req", 16'(mem_req_o), 16'h1);
    chk("rd_we", 16'(mem_we_o), 16'h0);
    chk("rd_addr", 16'(mem_addr_o), 16'h042);
    chk("rd_wdata_kept", 16'(mem_wdata_o), 16'hA5);
    chk("rd_nodone", 16'(done_o), 16'h0);
    mem_ack_i = 1'b1; mem_rdata_i = 8'h3C;
    tick();
    mem_ack_i = 1'b0; mem_rdata_i = 8'h00;
    chk("rd_done", 16'(done_o), 16'h1);
    chk("rd_err", 16'(err_o), 16'h0);
    chk("rd_rdata", 16'(rdata_o), 16'h3C);
    tick();

    // READ with no ack -> timeout after 4 request cycles
    issue(3'd1, 1'b0, 9'h050, 8'h00);
    n = 0;
    for (int i = 0; i < 10 && mem_req_o; i++) begin
      n++;
      tick();
    end
    chk("to_req_cycles", 16'(n), 16'd4);
    chk("to_done", 16'(done_o), 16'h1);
    chk("to_err", 16'(err_o), 16'h1);
    chk("to_rdata_kept", 16'(rdata_o), 16'h3C);
    tick();
    chk("to_idle", 16'(op_ready_o), 16'h1);

    // READ with ack on the 4th (last allowed) cycle -> success
    issue(3'd1, 1'b0, 9'h051, 8'h00);
    tick(); tick(); tick();
    chk("to4_req", 16'(mem_req_o), 16'h1);
    chk("to4_nodone", 16'(done_o), 16'h0);
    mem_ack_i = 1'b1; mem_rdata_i = 8'h77;
    tick();
    mem_ack_i = 1'b0; mem_rdata_i = 8'h00;
    chk("to4_done", 16'(done_o), 16'h1);
    chk("to4_err", 16'(err_o), 16'h0);
    chk("to4_rdata", 16'(rdata_o), 16'h77);
    tick();

    // Illegal opcode 7
    issue(3'd7, 1'b0, 9'h0AA, 8'h00);
    chk("ill_done", 16'(done_o), 16'h1);
    chk("ill_err", 16'(err_o), 16'h1);
    chk("ill_mar", 16'(mar_o), 16'h100);
    tick();
    chk("ill_err_clr", 16'(err_o), 16'h0);

    // Reset while a bus request is outstanding
    issue(3'd1, 1'b0, 9'h010, 8'h00);
    chk("rb_req", 16'(mem_req_o), 16'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rb_req_drop", 16'(mem_req_o), 16'h0);
    chk("rb_nodone", 16'(done_o), 16'h0);
    chk("rb_ready", 16'(op_ready_o), 16'h1);
    chk("rb_mar", 16'(mar_o), 16'h000);
    tick();
    chk("rb_nodone2", 16'(done_o), 16'h0);

    // op_valid held high: address ops accepted every 2 cycles
    op_valid_i = 1'b1; op_i = 3'd5; mode_i = 1'b0; operand_i = 9'h001;
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done_o) dones++;
    end
    op_valid_i = 1'b0; op_i = 3'd0; operand_i = 9'h000;
    chk("stream_dones", 16'(dones), 16'd3);
    chk("stream_mar", 16'(mar_o), 16'h003);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_access_unit.md
Name: memory_access_unit

Overview:
- Executes the memory operation issued by the control sequencer each instruction (memory_op_e: NOP, READ, WRITE, ABSOLUTE, REL_SUB, REL_ADD), using memory_addr_mode_e to form the address.
- Holds the 9-bit memory address register (MAR) and drives the external RAM bus.
- Sits directly downstream of the control decoder, between it and the RAM/IO bus.
- Reports completion with a one-cycle done pulse so the sequencer can advance.

Parameters:
ADDR_W, 9, address bus width; equals ADDR_BUS_WIDTH.
DATA_W, 8, data bus width.
TIMEOUT_CYCLES, 16, maximum mem_req cycles without mem_ack before abort; 0 disables the timeout.

Ports:
clk  input  1  system clock; the only clock.
rst  input  1  synchronous, active-high reset.
op_valid_i  input  1  operation request from the control sequencer.
op_ready_o  output  1  unit can accept an operation.
op_i  input  3  memory_op_e ordinal: NOP=0, READ=1, WRITE=2, ABSOLUTE=3, REL_SUB=4, REL_ADD=5.
mode_i  input  1  memory_addr_mode_e: ABSOLUTE=0, RELATIVE=1.
operand_i  input  ADDR_W  address or offset.
wdata_i  input  DATA_W  store data.
rdata_o  output  DATA_W  last loaded data.
mar_o  output  ADDR_W  current MAR.
done_o  output  1  one-cycle completion pulse.
err_o  output  1  one-cycle error pulse, coincident with done_o.
mem_req_o  output  1  bus request.
mem_we_o  output  1  1 = write, 0 = read.
mem_addr_o  output  ADDR_W  bus address.
mem_wdata_o  output  DATA_W  bus write data.
mem_rdata_i  input  DATA_W  bus read data, valid when mem_ack_i is high.
mem_ack_i  input  1  bus acknowledge.

Behaviour:
- Reset (synchronous, at the rising edge with rst=1; overrides everything, including an operation in flight): state IDLE; MAR=0; rdata_o=0; done_o=0; err_o=0; mem_req_o=0; mem_we_o=0; mem_addr_o=0; mem_wdata_o=0; timeout counter=0. The bus request drops in the first cycle after reset with no done pulse. The bus slave must tolerate a withdrawn request.
- FSM states: IDLE, BUS, DONE.
- op_ready_o = (state==IDLE).
- An operation is accepted at an edge where op_valid_i and op_ready_o are both high. op_i, mode_i, operand_i and wdata_i are sampled only at that edge.
- NOP, ABSOLUTE, REL_ADD, REL_SUB: IDLE->DONE on acceptance.
  - ABSOLUTE: MAR <= operand.
  - REL_ADD: MAR <= (MAR+operand) mod 2^ADDR_W.
  - REL_SUB: MAR <= (MAR-operand) mod 2^ADDR_W.
  - NOP: MAR unchanged.
  - done_o is high in the cycle after acceptance. Throughput is one operation every 2 cycles.
- READ and WRITE:
  - Effective address EA = operand (mode ABSOLUTE) or (MAR+operand) mod 2^ADDR_W (mode RELATIVE). MAR is not modified.
  - IDLE->BUS on acceptance. mem_addr_o=EA, mem_we_o=(op==WRITE), mem_wdata_o=wdata (WRITE only; READ leaves it unchanged) are registered at that edge.
  - mem_req_o=1 throughout BUS. Address, we and wdata stay stable while in BUS.
  - At the edge where mem_ack_i is high in BUS: go to DONE; mem_req_o<=0; on READ, rdata_o<=mem_rdata_i.
  - Minimum latency: ack in the first BUS cycle gives done_o 2 cycles after acceptance.
- Timeout (TIMEOUT_CYCLES>0): the counter clears on entry to BUS and increments on each BUS cycle without ack. After TIMEOUT_CYCLES request cycles with no ack: go to DONE with err_o=1; rdata_o unchanged; mem_req_o drops. Ack on the final allowed cycle counts as success.
- Illegal op_i (6 or 7): treated as NOP with err_o=1 alongside done_o; MAR unchanged.
- DONE always returns to IDLE in the next cycle. done_o and err_o are registered outputs.
- mar_o reflects MAR directly (registered).
- mem_ack_i is ignored outside BUS.

Test Plan:
- Reset -> all outputs 0 and op_ready_o=1. Assert rst while in BUS with mem_req_o=1 -> the next cycle has mem_req_o=0, state IDLE, and no done pulse.
- ABSOLUTE 0x1F0, then REL_ADD 0x020 -> mar_o=0x010 (wrap), done_o one cycle after each acceptance. Then REL_SUB 0x011 -> mar_o=0x1FF.
- MAR=0x100; WRITE RELATIVE operand 0x005 wdata 0xA5; ack on the 3rd BUS cycle -> mem_addr_o=0x105, mem_we_o=1, mem_wdata_o=0xA5 stable for 3 cycles; done_o in the following cycle; MAR stays 0x100.
- READ ABSOLUTE 0x042; ack in the first BUS cycle with mem_rdata_i=0x3C -> rdata_o=0x3C, done_o 2 cycles after acceptance, err_o=0.
- TIMEOUT_CYCLES=4; READ with no ack -> mem_req_o high exactly 4 cycles, then done_o=err_o=1 and rdata_o unchanged. Repeat with ack on cycle 4 -> success, err_o=0.
- op_i=7 -> done_o=err_o=1 and MAR unchanged. op_valid_i held high continuously -> an acceptance every 2 cycles for address ops.
